// File: rtl/tournament_predictor_p.sv
// Tournament branch predictor: global PHT, per-PC local history + local PHT, and a
// global-indexed choice table, with a registered lookup stage and separate resolve port.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// S_INIT  | sweeping every table to its reset value, one entry per cycle
// S_READY | lookups and resolves accepted
module tournament_predictor_p #(
  parameter int PC_W      = 32,
  parameter int GHR_W     = 12,
  parameter int LHT_IDX_W = 10,
  parameter int LHIST_W   = 10,
  parameter int CTR_W     = 2
) (
  input  logic             clock,
  input  logic             reset,
  output logic             ready,
  input  logic             lu_valid,
  input  logic [PC_W-1:0]  lu_pc,
  output logic             pr_valid,
  output logic             pr_taken,
  output logic             pr_gpred,
  output logic             pr_lpred,
  output logic             pr_use_local,
  output logic [GHR_W-1:0] pr_ghr,
  input  logic             rs_valid,
  input  logic [PC_W-1:0]  rs_pc,
  input  logic             rs_taken,
  input  logic [GHR_W-1:0] rs_ghr,
  input  logic             rs_gpred,
  input  logic             rs_lpred,
  input  logic             rs_mispredict
);

  localparam int IDX_W = (GHR_W > LHT_IDX_W) ? ((GHR_W > LHIST_W) ? GHR_W : LHIST_W)
                                             : ((LHT_IDX_W > LHIST_W) ? LHT_IDX_W : LHIST_W);
  localparam logic [CTR_W-1:0] CTR_INIT = {1'b0, {(CTR_W-1){1'b1}}};

  typedef enum logic {S_INIT, S_READY} state_t;

  state_t                 state;
  logic [IDX_W-1:0]       idx;
  logic [GHR_W-1:0]       ghr;

  logic [CTR_W-1:0]       gpht [2**GHR_W];
  logic [CTR_W-1:0]       cht  [2**GHR_W];
  logic [CTR_W-1:0]       lpht [2**LHIST_W];
  logic [LHIST_W-1:0]     lht  [2**LHT_IDX_W];

  logic [LHT_IDX_W-1:0]   lu_lht_idx;
  logic [LHIST_W-1:0]     lu_hist;
  logic                   lu_gpred;
  logic                   lu_lpred;
  logic                   lu_use_local;
  logic                   lu_taken;

  logic [LHT_IDX_W-1:0]   rs_lht_idx;
  logic [LHIST_W-1:0]     rs_hist;
  logic                   rs_recover;
  logic                   unused_pc_bits;

  function automatic logic [CTR_W-1:0] ctr_train(input logic [CTR_W-1:0] c, input logic up);
    if (up) return (c == '1) ? c : c + CTR_W'(1);
    else    return (c == '0) ? c : c - CTR_W'(1);
  endfunction

  // Lookup reads the arrays as they stand before the edge, so a same-cycle resolve is read-old.
  assign lu_lht_idx   = lu_pc[LHT_IDX_W+1:2];
  assign lu_hist      = lht[lu_lht_idx];
  assign lu_gpred     = gpht[ghr][CTR_W-1];
  assign lu_lpred     = lpht[lu_hist][CTR_W-1];
  assign lu_use_local = cht[ghr][CTR_W-1];
  assign lu_taken     = lu_use_local ? lu_lpred : lu_gpred;

  assign rs_lht_idx   = rs_pc[LHT_IDX_W+1:2];
  assign rs_hist      = lht[rs_lht_idx];
  assign rs_recover   = rs_valid && rs_mispredict;

  assign unused_pc_bits = ^{lu_pc[PC_W-1:LHT_IDX_W+2], lu_pc[1:0],
                            rs_pc[PC_W-1:LHT_IDX_W+2], rs_pc[1:0]};

  always_ff @(posedge clock) begin
    if (!reset) begin
      state        <= S_INIT;
      idx          <= '0;
      ready        <= 1'b0;
      pr_valid     <= 1'b0;
      pr_taken     <= 1'b0;
      pr_gpred     <= 1'b0;
      pr_lpred     <= 1'b0;
      pr_use_local <= 1'b0;
      pr_ghr       <= '0;
      ghr          <= '0;
    end else begin
      pr_valid <= 1'b0;
      case (state)
        S_INIT: begin
          gpht[idx[GHR_W-1:0]]     <= CTR_INIT;
          cht[idx[GHR_W-1:0]]      <= CTR_INIT;
          lpht[idx[LHIST_W-1:0]]   <= CTR_INIT;
          lht[idx[LHT_IDX_W-1:0]]  <= '0;
          if (idx == '1) begin
            state <= S_READY;
            ready <= 1'b1;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        S_READY: begin
          if (lu_valid && !rs_recover) begin
            pr_valid     <= 1'b1;
            pr_taken     <= lu_taken;
            pr_gpred     <= lu_gpred;
            pr_lpred     <= lu_lpred;
            pr_use_local <= lu_use_local;
            pr_ghr       <= ghr;
            ghr          <= {ghr[GHR_W-2:0], lu_taken};
          end
          if (rs_valid) begin
            gpht[rs_ghr]     <= ctr_train(gpht[rs_ghr], rs_taken);
            lpht[rs_hist]    <= ctr_train(lpht[rs_hist], rs_taken);
            lht[rs_lht_idx]  <= {rs_hist[LHIST_W-2:0], rs_taken};
            // The chooser only learns when the two components disagreed.
            if (rs_gpred != rs_lpred)
              cht[rs_ghr] <= ctr_train(cht[rs_ghr], rs_lpred == rs_taken);
            if (rs_mispredict)
              ghr <= {rs_ghr[GHR_W-2:0], rs_taken};
          end
        end
        default: begin
          state <= S_INIT;
          idx   <= '0;
          ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/tournament_predictor_p.md
Name:
tournament_predictor_p

Overview:
Parametrised, pipelined tournament branch predictor for the fetch front end. It combines a global-history PHT, a per-PC local-history predictor and a global-indexed choice table. Compared with the fixed 12/10-bit tournament predictor, it adds configurable table sizes and counter width. It also adds:
- a registered lookup stage;
- a separate non-speculative resolve/update port;
- a speculative GHR with mispredict recovery;
- a table-initialisation FSM.

Parameters:
PC_W, 32, PC width
GHR_W, 12, global history bits; global PHT and choice table have 2^GHR_W entries
LHT_IDX_W, 10, local history table index bits, taken from PC[LHT_IDX_W+1:2]
LHIST_W, 10, local history length; local PHT has 2^LHIST_W entries
CTR_W, 2, saturating counter width for all PHT and choice entries

Ports:
clock  in  1  rising-edge clock
reset  in  1  synchronous reset, active-low (asserted when 0)
ready  out  1  1 when the initialisation sweep is done and lookups are accepted
lu_valid  in  1  lookup request
lu_pc  in  PC_W  lookup PC
pr_valid  out  1  prediction valid, one cycle after an accepted lookup
pr_taken  out  1  final prediction
pr_gpred  out  1  global component prediction
pr_lpred  out  1  local component prediction
pr_use_local  out  1  1 if the choice counter selected the local component
pr_ghr  out  GHR_W  GHR snapshot used for this lookup (pre-update)
rs_valid  in  1  branch resolved
rs_pc  in  PC_W  resolved branch PC
rs_taken  in  1  actual outcome
rs_ghr  in  GHR_W  pr_ghr snapshot returned with the branch
rs_gpred  in  1  pr_gpred returned with the branch
rs_lpred  in  1  pr_lpred returned with the branch
rs_mispredict  in  1  final prediction differed from outcome

Behaviour:
- Counter threshold: a counter predicts taken when its MSB is 1. Saturating: +1 on taken, capped at 2^CTR_W-1; −1 on not-taken, floored at 0.
- Choice counter: MSB 1 selects local.
- Reset (reset==0): FSM enters INIT.
  - idx=0; ready=0, pr_valid=0, all pr_* outputs=0, GHR=0.
- INIT: one entry cleared per cycle in every table at address idx (address wrapped to each table's size).
  - PHT/choice entries are written to weakly-not-taken, 2^(CTR_W-1)-1. For CTR_W=2 this is 01.
  - LHT entries are written to 0.
  - idx increments until it reaches max(2^GHR_W, 2^LHT_IDX_W, 2^LHIST_W)-1. On the next edge the FSM goes to READY and ready=1.
  - lu_valid and rs_valid are ignored during INIT.
- Reset asserted in any state restarts INIT from idx=0.
- Lookup (READY, lu_valid=1), read combinationally from current table contents:
  - gpred = gPHT[GHR] MSB.
  - lhist = LHT[lu_pc idx].
  - lpred = lPHT[lhist] MSB.
  - use_local = CHT[GHR] MSB.
  - taken = use_local ? lpred : gpred.
  - All results are registered; pr_valid=1 on the next cycle with pr_ghr = GHR before update.
  - Speculative update the same edge: GHR <= {GHR[GHR_W-2:0], taken}.
- No lookup: pr_valid=0 next cycle and pr_* hold their values.
- Resolve (READY, rs_valid=1), all updates on the same edge:
  - gPHT[rs_ghr] is trained with rs_taken.
  - lPHT[LHT[rs_pc idx]] is trained with rs_taken, using the LHT value before this edge.
  - LHT[rs_pc idx] <= {hist[LHIST_W-2:0], rs_taken}.
  - If rs_gpred != rs_lpred: CHT[rs_ghr] increments when rs_lpred==rs_taken and decrements otherwise. If they are equal, the CHT is unchanged.
- Mispredict (rs_valid & rs_mispredict): GHR <= {rs_ghr[GHR_W-2:0], rs_taken}.
  - This overrides the speculative update.
  - A lookup in the same cycle is dropped: pr_valid=0 next cycle, and the dropped lookup does not shift the GHR.
- Simultaneous lookup and non-mispredicting resolve: the lookup reads table values from before the edge (read-old). Both updates commit.
- rs_valid with rs_mispredict=0 never changes the GHR.
- Only the signals above are registered outputs; there are no combinational paths from inputs to outputs.

Test Plan:
- Reset/init: hold reset=0 for 3 cycles, then release. ready stays 0 for exactly 4096 cycles (defaults), then becomes 1; pr_valid=0 throughout. Reassert reset at mid-sweep cycle 2000: ready=0 and the sweep restarts, so a full 4096 cycles are needed again.
- First lookup after init: lu_pc=0x100. Required next cycle: pr_valid=1, pr_taken=0, pr_gpred=0, pr_lpred=0, pr_use_local=0, pr_ghr=0. The following lookup shows pr_ghr=0.
- Training: resolve PC 0x200 taken twice with rs_ghr=0 and no mispredict. Then gPHT[0] goes 01→10→11. A lookup with GHR=0 gives pr_gpred=1. Local history of 0x200 becomes 0b11, and lPHT[0] and lPHT[1] are each 10.
- Mispredict recovery: after 3 speculative not-taken lookups (GHR=0), apply rs_valid=1, rs_mispredict=1, rs_taken=1, rs_ghr=0x005. Required: GHR=0x00B. A lookup issued in the same cycle yields pr_valid=0, and the next accepted lookup reports pr_ghr=0x00B.
- Choice training: rs_gpred=0, rs_lpred=1, rs_taken=1 at rs_ghr=0x0 moves CHT[0] from 01 to 10. A subsequent lookup with GHR=0 gives pr_use_local=1. With rs_gpred=rs_lpred, CHT is unchanged.
- Saturation/parameters: run 10 taken resolves to one gPHT entry; it stays at 11. Repeat with CTR_W=3, GHR_W=4, LHT_IDX_W=3, LHIST_W=5: init lasts 32 cycles, the entry saturates at 111, and the initial value is 011.
